// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller.
// State encoding, config register map and reset defaults.
package irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    localparam logic [1:0] CFG_MASK    = 2'd0;
    localparam logic [1:0] CFG_PENDING = 2'd1;
    localparam logic [1:0] CFG_STATUS  = 2'd2;
    localparam logic [1:0] CFG_VBASE   = 2'd3;

    localparam logic [31:0] VEC_RESET_DFLT = 32'h0000_0080;

endpackage

// File: rtl/irq_if.sv
// Interrupt handshake and config register port.
// The core is the master; the controller is the slave.
interface irq_if;

    logic        irq_req;
    logic        irq_ack;
    logic        irq_eoi;
    logic [31:0] irq_vector;
    logic [3:0]  irq_id;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;

    modport master (
        input  irq_req,
        input  irq_vector,
        input  irq_id,
        input  cfg_rdata,
        output irq_ack,
        output irq_eoi,
        output cfg_we,
        output cfg_addr,
        output cfg_wdata
    );

    modport slave (
        output irq_req,
        output irq_vector,
        output irq_id,
        output cfg_rdata,
        input  irq_ack,
        input  irq_eoi,
        input  cfg_we,
        input  cfg_addr,
        input  cfg_wdata
    );

endinterface

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser plus an edge flop for one interrupt line.
// rise is high for one cycle per synchronised 0->1 transition.
module irq_sync_edge (
    input  logic clock,
    input  logic reset_n,
    input  logic irq_in,
    output logic rise
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    // shift the raw line through the synchroniser chain
    always_comb begin
        s1_d = irq_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // synchroniser and edge-detect registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/irq_controller.sv
// Interrupt source side of the ControlUnit handshake.
// Latches edges as pending, requests service, supplies the vector.
module irq_controller
    import irq_pkg::*;
#(
    parameter int          NUM_SRC   = 8,
    parameter logic [31:0] VEC_RESET = VEC_RESET_DFLT
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] irq_src,
    irq_if.slave               bus
);

    irq_state_e         state_q, state_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [31:0]        base_q, base_d;
    logic [31:0]        vec_q, vec_d;
    logic [3:0]         id_q, id_d;
    logic               req_q, req_d;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] w1c;
    logic [3:0]         sel_id;
    logic               any_elig;
    logic               take;
    logic [31:0]        rdata;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
        irq_sync_edge u_sync (
            .clock   (clock),
            .reset_n (reset_n),
            .irq_in  (irq_src[g]),
            .rise    (rise[g])
        );
    end

    // lowest-index eligible source wins
    always_comb begin
        elig     = pend_q & mask_q;
        any_elig = |elig;
        sel_id   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                sel_id = 4'(i);
            end
        end
    end

    // request/service handshake with the core
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (any_elig) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!any_elig) begin
                    state_d = ST_IDLE;
                end else if (bus.irq_ack) begin
                    state_d = ST_SERVICE;
                    take    = 1'b1;
                end
            end
            ST_SERVICE: begin
                if (bus.irq_eoi) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // request flag, serviced id and handler vector
    always_comb begin
        req_d = (state_d == ST_REQ);
        id_d  = id_q;
        vec_d = vec_q;
        if (take) begin
            id_d  = sel_id;
            vec_d = base_q + {26'b0, sel_id, 2'b00};
        end
    end

    // config registers; a fresh edge beats any clear
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            ack_clr[i] = take && (sel_id == 4'(i));
        end
        w1c = '0;
        if (bus.cfg_we && bus.cfg_addr == CFG_PENDING) begin
            w1c = bus.cfg_wdata[NUM_SRC-1:0];
        end
        pend_d = (pend_q & ~(ack_clr | w1c)) | rise;
        mask_d = mask_q;
        if (bus.cfg_we && bus.cfg_addr == CFG_MASK) begin
            mask_d = bus.cfg_wdata[NUM_SRC-1:0];
        end
        base_d = base_q;
        if (bus.cfg_we && bus.cfg_addr == CFG_VBASE) begin
            base_d = {bus.cfg_wdata[31:2], 2'b00};
        end
    end

    // combinational register read
    always_comb begin
        rdata = '0;
        unique case (bus.cfg_addr)
            CFG_MASK:    rdata[NUM_SRC-1:0] = mask_q;
            CFG_PENDING: rdata[NUM_SRC-1:0] = pend_q;
            CFG_STATUS:  rdata = {26'b0, state_q, id_q};
            CFG_VBASE:   rdata = base_q;
            default:     rdata = '0;
        endcase
    end

    // state registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            pend_q  <= '0;
            base_q  <= VEC_RESET;
            vec_q   <= VEC_RESET;
            id_q    <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            base_q  <= base_d;
            vec_q   <= vec_d;
            id_q    <= id_d;
            req_q   <= req_d;
        end
    end

    assign bus.irq_req    = req_q;
    assign bus.irq_id     = id_q;
    assign bus.irq_vector = vec_q;
    assign bus.cfg_rdata  = rdata;

endmodule

// File: tb/tb_irq_controller.sv
// Randomised and directed bench for irq_controller.
// A cycle-level service model predicts every output.
module tb_irq_controller;

    logic       clock;
    logic       reset_n;
    logic [7:0] irq_src;

    irq_if bus ();

    irq_controller #(
        .NUM_SRC   (8),
        .VEC_RESET (32'h0000_0080)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .irq_src (irq_src),
        .bus     (bus.slave)
    );

    int checks;
    int fails;

    // model: sampled line history, registers, service mode
    logic [7:0]  h_a, h_b, h_c;
    logic [7:0]  m_mask, m_pend;
    logic [31:0] m_base, m_vec;
    logic [3:0]  m_id;
    int          m_mode;

    logic [7:0]  cur_src;
    logic [31:0] rd;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        h_a = '0; h_b = '0; h_c = '0;
        m_mask = '0; m_pend = '0;
        m_base = 32'h80; m_vec = 32'h80;
        m_id = '0; m_mode = 0;
    endtask

    function automatic logic [31:0] model_read(logic [1:0] a);
        case (a)
            2'd0:    return {24'b0, m_mask};
            2'd1:    return {24'b0, m_pend};
            2'd2:    return {26'b0, m_mode[1:0], m_id};
            default: return m_base;
        endcase
    endfunction

    // advance the model by one clock edge with the given inputs
    task automatic model_update(logic [7:0] src, logic ack, logic eoi,
                                logic we, logic [1:0] a, logic [31:0] wd);
        logic [7:0] edges, elig, clr;
        int win;
        int nmode;
        edges = h_b & ~h_c;
        elig  = m_pend & m_mask;
        win   = -1;
        for (int i = 7; i >= 0; i--) if (elig[i]) win = i;
        clr   = '0;
        nmode = m_mode;
        if (m_mode == 0) begin
            if (elig != 0) nmode = 1;
        end else if (m_mode == 1) begin
            if (elig == 0) nmode = 0;
            else if (ack) begin
                nmode = 2;
                m_id  = 4'(win);
                m_vec = m_base + 32'(4 * win);
                clr[win] = 1'b1;
            end
        end else if (eoi) begin
            nmode = 0;
        end
        m_mode = nmode;
        if (we && a == 2'd1) clr = clr | wd[7:0];
        m_pend = (m_pend & ~clr) | edges;
        if (we && a == 2'd0) m_mask = wd[7:0];
        if (we && a == 2'd3) m_base = wd & 32'hFFFF_FFFC;
        h_c = h_b; h_b = h_a; h_a = src;
    endtask

    task automatic step(logic [7:0] src, logic ack, logic eoi,
                        logic we, logic [1:0] a, logic [31:0] wd);
        irq_src       = src;
        cur_src       = src;
        bus.irq_ack   = ack;
        bus.irq_eoi   = eoi;
        bus.cfg_we    = we;
        bus.cfg_addr  = a;
        bus.cfg_wdata = wd;
        #1;
        check("rdata", bus.cfg_rdata, model_read(a));
        model_update(src, ack, eoi, we, a, wd);
        @(posedge clock);
        @(negedge clock);
        check("req", {31'b0, bus.irq_req}, {31'b0, m_mode == 1});
        check("id", {28'b0, bus.irq_id}, {28'b0, m_id});
        check("vector", bus.irq_vector, m_vec);
    endtask

    task automatic idle(int n, logic [7:0] src);
        for (int k = 0; k < n; k++) step(src, 0, 0, 0, 2'd0, 0);
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] wd);
        step(cur_src, 0, 0, 1, a, wd);
    endtask

    task automatic peek(logic [1:0] a, output logic [31:0] d);
        bus.cfg_we   = 1'b0;
        bus.irq_ack  = 1'b0;
        bus.irq_eoi  = 1'b0;
        bus.cfg_addr = a;
        #1;
        d = bus.cfg_rdata;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_req", {31'b0, bus.irq_req}, 32'd0);
        check("rst_id", {28'b0, bus.irq_id}, 32'd0);
        check("rst_vec", bus.irq_vector, 32'h80);
        peek(2'd0, rd);
        check("rst_mask", rd, 32'd0);
        peek(2'd3, rd);
        check("rst_base", rd, 32'h80);
        peek(2'd1, rd);
        check("rst_pend", rd, 32'd0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        reset_n = 1'b1;
        irq_src = '0;
        cur_src = '0;
        bus.irq_ack = 0; bus.irq_eoi = 0;
        bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_wdata = 0;
        model_reset();
        @(negedge clock);
        do_reset();

        // single source, vector arithmetic
        wr(2'd0, 32'h04);
        step(8'h04, 0, 0, 0, 2'd0, 0);
        idle(2, 8'h00);
        check("t2_req_early", {31'b0, bus.irq_req}, 32'd0);
        idle(1, 8'h00);
        check("t2_req", {31'b0, bus.irq_req}, 32'd1);
        step(8'h00, 1, 0, 0, 2'd0, 0);
        check("t2_id", {28'b0, bus.irq_id}, 32'd2);
        check("t2_vec", bus.irq_vector, 32'h88);
        peek(2'd1, rd);
        check("t2_pend", rd, 32'd0);
        step(8'h00, 0, 1, 0, 2'd0, 0);

        // priority between two pending sources
        wr(2'd0, 32'hFF);
        step(8'h22, 0, 0, 0, 2'd0, 0);
        idle(3, 8'h00);
        check("t3_req", {31'b0, bus.irq_req}, 32'd1);
        step(8'h00, 1, 0, 0, 2'd0, 0);
        check("t3_id1", {28'b0, bus.irq_id}, 32'd1);
        step(8'h00, 0, 1, 0, 2'd0, 0);
        idle(1, 8'h00);
        check("t3_rereq", {31'b0, bus.irq_req}, 32'd1);
        step(8'h00, 1, 0, 0, 2'd0, 0);
        check("t3_id5", {28'b0, bus.irq_id}, 32'd5);
        check("t3_vec5", bus.irq_vector, 32'h94);
        step(8'h00, 0, 1, 0, 2'd0, 0);

        // masked source holds pending until unmasked
        wr(2'd0, 32'h00);
        step(8'h08, 0, 0, 0, 2'd0, 0);
        idle(4, 8'h00);
        check("t4_noreq", {31'b0, bus.irq_req}, 32'd0);
        peek(2'd1, rd);
        check("t4_pend", rd, 32'h08);
        wr(2'd0, 32'h08);
        idle(1, 8'h00);
        check("t4_req", {31'b0, bus.irq_req}, 32'd1);
        step(8'h00, 1, 0, 0, 2'd0, 0);
        step(8'h00, 0, 1, 0, 2'd0, 0);

        // withdrawal by write-one-to-clear
        wr(2'd0, 32'h01);
        step(8'h01, 0, 0, 0, 2'd0, 0);
        idle(3, 8'h00);
        check("t5_req", {31'b0, bus.irq_req}, 32'd1);
        wr(2'd1, 32'h01);
        idle(1, 8'h00);
        check("t5_drop", {31'b0, bus.irq_req}, 32'd0);
        peek(2'd2, rd);
        check("t5_state", {30'b0, rd[5:4]}, 32'd0);

        // new edge on the ack cycle, stray ack, re-request
        step(8'h01, 0, 0, 0, 2'd0, 0);
        idle(3, 8'h00);
        check("t6_req", {31'b0, bus.irq_req}, 32'd1);
        step(8'h01, 0, 0, 0, 2'd0, 0);
        step(8'h00, 0, 0, 0, 2'd0, 0);
        step(8'h00, 1, 0, 0, 2'd0, 0);
        peek(2'd1, rd);
        check("t6_pend", rd, 32'h01);
        step(8'h00, 1, 0, 0, 2'd0, 0);
        peek(2'd2, rd);
        check("t6_stray", {30'b0, rd[5:4]}, 32'd2);
        step(8'h00, 0, 1, 0, 2'd0, 0);
        idle(1, 8'h00);
        check("t6_rereq", {31'b0, bus.irq_req}, 32'd1);
        step(8'h00, 1, 0, 0, 2'd0, 0);
        step(8'h00, 0, 1, 0, 2'd0, 0);

        // randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] nsrc;
            if (n == 1500) begin
                do_reset();
            end
            nsrc = cur_src;
            if ($urandom_range(0, 2) == 0) begin
                nsrc = nsrc ^ (8'($urandom) & 8'($urandom));
            end
            step(nsrc,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 9) == 0,
                 2'($urandom),
                 $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
